boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port nreset  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port rx_data  input  8  incoming load byte.
REQ-004 SHALL have port rx_valid  input  1  rx_data valid.
REQ-005 SHALL have port rx_ready  output  1  byte accepted when rx_valid & rx_ready at a clk edge.
REQ-006 SHALL have port sel  output  1  boot RAM select.
REQ-007 SHALL have port r  output  1  boot RAM read strobe.
REQ-008 SHALL have port w  output  2  boot RAM byte write enables; [1] high byte, [0] low byte.
REQ-009 SHALL have port addr  output  12  boot RAM word address, bits [12:1].
REQ-010 SHALL have port dout  output  16  write data to boot RAM.
REQ-011 SHALL have port din  input  16  read data from boot RAM, valid the cycle after a read strobe.
REQ-012 SHALL have port cpu_hold  output  1  high holds the CPU in reset until load completes.
REQ-013 SHALL have port done  output  1  load completed successfully, sticky.
REQ-014 SHALL have port error  output  1  load aborted, sticky.

Function
REQ-015 SHALL accept this stream format: length N as 2 bytes, high byte first, then N words as 2 bytes each, high byte first.
REQ-016 SHALL implement states LEN_H, LEN_L, DAT_H, DAT_L, WRITE, DONE, ERROR, plus RD and CMP when REQ-030 applies.
REQ-017 SHALL drive rx_ready = 1 only in LEN_H, LEN_L, DAT_H and DAT_L, decoded from state, and 0 while nreset is low.
REQ-018 SHALL advance LEN_H->LEN_L->DAT_H and DAT_H->DAT_L->WRITE, one step per accepted byte; with no accepted byte, state holds.
REQ-019 SHALL, on LEN_L accept, go to DONE if N = 0, to ERROR if N > 4096, else to DAT_H; a 13-bit word counter is cleared to 0.
REQ-020 SHALL, in WRITE, drive for exactly one cycle: sel = 1, r = 0, w = 2'b11, addr = counter[11:0], dout = assembled word.
REQ-021 SHALL drive sel, r and w to 0 in every cycle other than the WRITE/RD cycles; addr and dout hold their last values.
REQ-022 SHALL, after WRITE, increment the counter and go to DONE if the counter equals N, else to DAT_H.
REQ-023 SHALL meet these latencies: last data byte accepted at cycle t -> write strobe at t+1 -> rx_ready high at t+2 (or done at t+2).
REQ-024 SHALL, in DONE, hold done = 1 and cpu_hold = 0, and ignore further bytes until reset.
REQ-025 SHALL, in ERROR, hold error = 1, cpu_hold = 1, done = 0 and issue no RAM strobes until reset.
REQ-026 SHALL give the final word of N = 4096 the address 0xFFF, with no wrap-around and no write past N.

Reset
REQ-027 SHALL, when nreset is sampled low at a clk edge, set: state LEN_H, counter 0, sel 0, r 0, w 2'b00, addr 0, dout 0, done 0, error 0, cpu_hold 1.
REQ-028 SHALL abandon any partial load on a reset mid-load; the next stream writes again from address 0, and earlier RAM contents are left untouched.
REQ-029 SHALL register every output except rx_ready.

Configuration
REQ-030 SHALL, with macro BOOT_LOADER_VERIFY_EN defined, run WRITE -> RD -> CMP. RD drives one cycle of sel = 1, r = 1, w = 0 at the same addr. CMP compares din with the written word: on mismatch go to ERROR, on match continue as in REQ-022.
REQ-031 SHALL, without BOOT_LOADER_VERIFY_EN, contain no RD or CMP state, ignore din, never assert r, and never enter ERROR on data (length check only).

Verification
REQ-032 SHALL cover: stream 00 02 12 34 AB CD -> writes 0x1234@0x000 and 0xABCD@0x001, w = 2'b11 for one cycle each; done = 1, cpu_hold = 0.
REQ-033 SHALL cover: stream 00 00 -> no sel pulse, done = 1 two cycles after the second byte is accepted.
REQ-034 SHALL cover: stream 10 01 -> error = 1, rx_ready = 0, no sel pulse, cpu_hold stays 1.
REQ-035 SHALL cover: 1-cycle rx_valid gaps, then nreset low after word 0 and a new stream 00 01 55 AA -> 0x55AA written @0x000, done = 1.
REQ-036 SHALL cover: N = 4096 with word i = i -> 4096 writes, last 0x0FFF@0xFFF, then done.
REQ-037 SHALL cover, with BOOT_LOADER_VERIFY_EN and a RAM model returning 0xDEAD for address 1: stream 00 02 00 01 00 02 -> error = 1 after the CMP of word 1, done = 0.

Source files
------------

// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed word stream and writes it into boot RAM.
// Define BOOT_LOADER_VERIFY_EN to read back and compare every written word.
module boot_loader (
  input  logic        clk,
  input  logic        nreset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        sel,
  output logic        r,
  output logic [1:0]  w,
  output logic [11:0] addr,
  output logic [15:0] dout,
  input  logic [15:0] din,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

`ifdef BOOT_LOADER_VERIFY_EN
  typedef enum logic [3:0] {
    StLenH, StLenL, StDatH, StDatL, StWrite, StDone, StError, StRd, StCmp
  } state_e;
`else
  typedef enum logic [3:0] {
    StLenH, StLenL, StDatH, StDatL, StWrite, StDone, StError
  } state_e;
`endif

  state_e      state_q;
  logic [12:0] cnt_q;
  logic [12:0] len_q;
  logic [7:0]  byte_q;
  logic        sel_q;
  logic        r_q;
  logic [1:0]  w_q;
  logic [11:0] addr_q;
  logic [15:0] dout_q;
  logic        done_q;
  logic        error_q;
  logic        hold_q;

  logic        accept;
  logic [15:0] rx_word;
  logic        last_word;

  always_comb begin
    rx_ready = 1'b0;
    if (nreset) begin
      case (state_q)
        StLenH, StLenL, StDatH, StDatL: rx_ready = 1'b1;
        default:                        rx_ready = 1'b0;
      endcase
    end
  end

  assign accept    = rx_valid & rx_ready;
  assign rx_word   = {byte_q, rx_data};
  // Counter reaches at most 4096, so 13 bits never overflow here.
  assign last_word = (cnt_q + 13'd1) == len_q;

`ifndef BOOT_LOADER_VERIFY_EN
  logic unused_din;
  assign unused_din = ^din;
`endif

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= StLenH;
      cnt_q   <= '0;
      len_q   <= '0;
      byte_q  <= '0;
      sel_q   <= 1'b0;
      r_q     <= 1'b0;
      w_q     <= 2'b00;
      addr_q  <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      // RAM strobes are single-cycle pulses unless re-armed below.
      sel_q <= 1'b0;
      r_q   <= 1'b0;
      w_q   <= 2'b00;
      unique case (state_q)
        StLenH: begin
          if (accept) begin
            byte_q  <= rx_data;
            state_q <= StLenL;
          end
        end
        StLenL: begin
          if (accept) begin
            cnt_q <= '0;
            if (rx_word == 16'd0) begin
              state_q <= StDone;
            end else if (rx_word > 16'd4096) begin
              error_q <= 1'b1;
              state_q <= StError;
            end else begin
              len_q   <= rx_word[12:0];
              state_q <= StDatH;
            end
          end
        end
        StDatH: begin
          if (accept) begin
            byte_q  <= rx_data;
            state_q <= StDatL;
          end
        end
        StDatL: begin
          if (accept) begin
            sel_q   <= 1'b1;
            w_q     <= 2'b11;
            addr_q  <= cnt_q[11:0];
            dout_q  <= rx_word;
            state_q <= StWrite;
          end
        end
`ifdef BOOT_LOADER_VERIFY_EN
        StWrite: begin
          sel_q   <= 1'b1;
          r_q     <= 1'b1;
          state_q <= StRd;
        end
        StRd: begin
          state_q <= StCmp;
        end
        StCmp: begin
          if (din != dout_q) begin
            error_q <= 1'b1;
            state_q <= StError;
          end else begin
            cnt_q <= cnt_q + 13'd1;
            if (last_word) begin
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
              state_q <= StDone;
            end else begin
              state_q <= StDatH;
            end
          end
        end
`else
        StWrite: begin
          cnt_q <= cnt_q + 13'd1;
          if (last_word) begin
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            state_q <= StDatH;
          end
        end
`endif
        StDone: begin
          done_q <= 1'b1;
          hold_q <= 1'b0;
        end
        StError: begin
          error_q <= 1'b1;
          hold_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        default: state_q <= StLenH;
      endcase
    end
  end

  assign sel      = sel_q;
  assign r        = r_q;
  assign w        = w_q;
  assign addr     = addr_q;
  assign dout     = dout_q;
  assign done     = done_q;
  assign error    = error_q;
  assign cpu_hold = hold_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed table, latency sequences, random streams
// against a stream-level reference model, and a RAM model for readback.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        nreset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        sel;
  logic        r;
  logic [1:0]  w;
  logic [11:0] addr;
  logic [15:0] dout;
  logic [15:0] din = 16'h0000;
  logic        cpu_hold;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  boot_loader dut (
    .clk      (clk),
    .nreset   (nreset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .sel      (sel),
    .r        (r),
    .w        (w),
    .addr     (addr),
    .dout     (dout),
    .din      (din),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  int          errors = 0;
  int          checks = 0;
  logic [15:0] mem [4096];
  logic        corrupt1 = 1'b0;
  logic [31:0] wr_obs [$];
  logic [31:0] exp_wr [$];
  logic [7:0]  stream [$];
  int          sel_cnt = 0;
  int          r_cnt = 0;
  logic        exp_done;
  logic        exp_err;

  // Boot RAM model; read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (sel && w[1]) mem[addr][15:8] <= dout[15:8];
    if (sel && w[0]) mem[addr][7:0]  <= dout[7:0];
    if (sel && r) din <= (corrupt1 && addr == 12'd1) ? 16'hDEAD : mem[addr];
  end

  always @(negedge clk) begin
    if (sel) sel_cnt++;
    if (r) r_cnt++;
    if (sel && w == 2'b11) wr_obs.push_back({4'h0, addr, dout});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    check("rx_ready_in_reset", {31'b0, rx_ready}, 32'd0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    wr_obs.delete();
    sel_cnt = 0;
    r_cnt   = 0;
  endtask

  task automatic reset_values();
    @(negedge clk);
    check("rst_sel", {31'b0, sel}, 32'd0);
    check("rst_r", {31'b0, r}, 32'd0);
    check("rst_w", {30'b0, w}, 32'd0);
    check("rst_addr", {20'b0, addr}, 32'd0);
    check("rst_dout", {16'b0, dout}, 32'd0);
    check("rst_done_error_hold", {29'b0, done, error, cpu_hold}, 32'd1);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    rx_data  = b;
    rx_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!rx_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  // Reference model: expected writes and final status from the raw byte stream.
  task automatic model_stream();
    int n;
    exp_wr.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (stream.size() >= 2) begin
      n = {16'd0, stream[0], stream[1]};
      if (n == 0) begin
        exp_done = 1'b1;
      end else if (n > 4096) begin
        exp_err = 1'b1;
      end else begin
        for (int i = 0; i < n; i++) begin
          if (3 + 2 * i < stream.size())
            exp_wr.push_back({4'h0, 12'(i), stream[2 + 2 * i], stream[3 + 2 * i]});
        end
        if (stream.size() >= 2 + 2 * n) exp_done = 1'b1;
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int bad;
    int lim;
    bad = 0;
    lim = (wr_obs.size() < exp_wr.size()) ? wr_obs.size() : exp_wr.size();
    check({tag, "_wr_count"}, wr_obs.size(), exp_wr.size());
    for (int i = 0; i < lim; i++) begin
      if (wr_obs[i] !== exp_wr[i]) begin
        if (bad == 0) $display("write %0d: got %h expected %h", i, wr_obs[i], exp_wr[i]);
        bad++;
      end
    end
    check({tag, "_wr_entries_bad"}, bad, 32'd0);
  endtask

  task automatic run_stream(input int gap_max, input string tag);
    int k;
    do_reset();
    foreach (stream[i]) begin
      repeat ($urandom_range(0, gap_max)) idle();
      send_byte(stream[i]);
    end
    model_stream();
    if (exp_done || exp_err) begin
      k = 0;
      @(negedge clk);
      while (!(done || error) && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    repeat (2) @(negedge clk);
    check({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
    check({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
    check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, !exp_done});
    compare_writes(tag);
`ifndef BOOT_LOADER_VERIFY_EN
    check({tag, "_no_read"}, r_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [3:0]  nb;
    logic [63:0] bytes;
    logic        ed;
    logic        ee;
    logic [3:0]  nwr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n;
    int k;
    tbl[0] = '{4'd2, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 4'd0};
    tbl[1] = '{4'd6, 64'h0002_1234_ABCD_0000, 1'b1, 1'b0, 4'd2};
    tbl[2] = '{4'd2, 64'h1001_0000_0000_0000, 1'b0, 1'b1, 4'd0};
    tbl[3] = '{4'd2, 64'hFFFF_0000_0000_0000, 1'b0, 1'b1, 4'd0};
    tbl[4] = '{4'd4, 64'h0001_FFFF_0000_0000, 1'b1, 1'b0, 4'd1};
    tbl[5] = '{4'd8, 64'h0003_0000_8001_7FFE, 1'b1, 1'b0, 4'd3};

    do_reset();
    reset_values();

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      stream.delete();
      for (int j = 0; j < int'(tbl[v].nb); j++) stream.push_back(tbl[v].bytes[63 - 8 * j -: 8]);
      run_stream(0, $sformatf("tbl%0d", v));
      check($sformatf("tbl%0d_done_const", v), {31'b0, done}, {31'b0, tbl[v].ed});
      check($sformatf("tbl%0d_error_const", v), {31'b0, error}, {31'b0, tbl[v].ee});
      check($sformatf("tbl%0d_nwr_const", v), wr_obs.size(), {28'b0, tbl[v].nwr});
      check($sformatf("tbl%0d_sel_pulses", v), sel_cnt, {28'b0, tbl[v].nwr} *
            (`ifdef BOOT_LOADER_VERIFY_EN 2 `else 1 `endif));
      if (tbl[v].ee) check($sformatf("tbl%0d_rx_ready_err", v), {31'b0, rx_ready}, 32'd0);
    end

`ifndef BOOT_LOADER_VERIFY_EN
    // Write / ready / done latency, then bytes ignored once done.
    do_reset();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    @(negedge clk);
    check("lat_w0_strobe", {11'b0, sel, w, addr, rx_ready}, {11'b0, 1'b1, 2'b11, 12'h000, 1'b0});
    check("lat_w0_dout", {16'b0, dout}, 32'h1234);
    @(negedge clk);
    check("lat_w0_after", {12'b0, sel, w, rx_ready, done}, {12'b0, 1'b0, 2'b00, 1'b1, 1'b0});
    check("lat_w0_hold_dout", {16'b0, dout}, 32'h1234);
    @(posedge clk);
    #1;
    send_byte(8'hAB);
    send_byte(8'hCD);
    @(negedge clk);
    check("lat_w1_strobe", {4'b0, sel, w, addr, dout}, {4'b0, 1'b1, 2'b11, 12'h001, 16'hABCD});
    @(negedge clk);
    check("lat_w1_done", {28'b0, sel, done, cpu_hold, rx_ready}, {28'b0, 4'b0100});
    @(posedge clk);
    #1;
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("done_ignores_rx", {30'b0, rx_ready, done}, 32'd1);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("done_no_extra_sel", sel_cnt, 32'd2);
    do_reset();
    reset_values();

    // N = 0: done two cycles after the second length byte.
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    @(negedge clk);
    check("n0_done_latency", {30'b0, done, cpu_hold}, 32'd2);
    check("n0_no_sel", sel_cnt, 32'd0);
    @(posedge clk);
    #1;
`endif

    // Reset mid-load with gapped bytes, then a fresh stream restarts at address 0.
    do_reset();
    send_byte(8'h00); idle();
    send_byte(8'h03); idle();
    send_byte(8'h11); idle();
    send_byte(8'h11); idle();
    repeat (3) idle();
    check("mid_first_write", wr_obs.size(), 32'd1);
    check("mid_mem0_first", {16'b0, mem[0]}, 32'h1111);
    nreset = 1'b0;
    idle();
    nreset = 1'b1;
    send_byte(8'h00); idle();
    send_byte(8'h01); idle();
    send_byte(8'h55); idle();
    send_byte(8'hAA);
    k = 0;
    @(negedge clk);
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("mid_done", {31'b0, done}, 32'd1);
    check("mid_wr_count", wr_obs.size(), 32'd2);
    check("mid_second_write", (wr_obs.size() > 1) ? wr_obs[1] : 32'hFFFF_FFFF, 32'h0000_55AA);
    check("mid_mem0_second", {16'b0, mem[0]}, 32'h55AA);
    @(posedge clk);
    #1;

    // Random streams against the reference model.
    for (int t = 0; t < 12; t++) begin
      stream.delete();
      if ($urandom_range(0, 5) == 0) begin
        n = 4097 + $urandom_range(0, 2000);
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
      end else begin
        n = $urandom_range(1, 20);
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) stream.push_back(8'($urandom));
      end
      run_stream(2, $sformatf("rnd%0d", t));
    end

    // Full 4096-word load, word i = i.
    stream.delete();
    stream.push_back(8'h10);
    stream.push_back(8'h00);
    for (int i = 0; i < 4096; i++) begin
      stream.push_back(8'(i >> 8));
      stream.push_back(8'(i));
    end
    run_stream(0, "full");
    check("full_last", (wr_obs.size() > 0) ? wr_obs[wr_obs.size() - 1] : 32'hFFFF_FFFF,
          32'h0FFF_0FFF);

`ifdef BOOT_LOADER_VERIFY_EN
    // Readback mismatch on word 1 aborts the load.
    corrupt1 = 1'b1;
    do_reset();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h02);
    k = 0;
    @(negedge clk);
    while (!error && !done && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check("vfy_error", {30'b0, error, done}, 32'd2);
    check("vfy_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    check("vfy_writes", wr_obs.size(), 32'd2);
    check("vfy_reads", r_cnt, 32'd2);
    corrupt1 = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
